// File: rtl/imem_loadable_if.sv
// Byte-stream program loader bundle for imem_loadable.
// The master side (boot agent or bench) drives bytes; the memory is the slave.
interface imem_loadable_if #(
    parameter int unsigned CNT_W = 7
) ();
    logic             ld_start;
    logic             ld_valid;
    logic [7:0]       ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic             ld_done;
    logic             ld_err;
    logic [CNT_W-1:0] ld_count;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last,
        input  ld_ready, ld_done, ld_err, ld_count
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last,
        output ld_ready, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/imem_loadable.sv
// Word-organised instruction memory with a combinational byte-addressed fetch port
// and a valid/ready byte loader; an FSM sequences post-reset clear, fetch and load.
module imem_loadable #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 64,
    parameter logic [XLEN-1:0] FILL_WORD = 32'h00000013
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [31:0]         A,
    output logic [XLEN-1:0]     RD,
    output logic                rd_valid,
    output logic                misalign,
    output logic                busy,
    imem_loadable_if.slave      ld
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LANES  = XLEN / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StClear, StReady, StLoad} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [XLEN-1:0]     asm_q, asm_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [XLEN-1:0]     mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     asm_new;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StClear;
            clr_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Single write port shared by the clear sweep and the loader.
    always_ff @(posedge CLK) begin
        if (mem_we && !Reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        asm_d     = asm_q;
        err_d     = err_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        asm_new   = asm_q;
        asm_new[8*lane_q +: 8] = ld.ld_data;

        unique case (state_q)
            StClear: begin
                mem_we   = 1'b1;
                mem_addr = clr_q;
                clr_d    = clr_q + 1'b1;
                if (clr_q == LAST_IDX) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (ld.ld_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (ld.ld_valid) begin
                    // A full array swallows bytes without touching lane or assembly state.
                    if (cnt_q == FULL_CNT) begin
                        err_d = 1'b1;
                    end else if (lane_q == LAST_LANE || ld.ld_last) begin
                        mem_we    = 1'b1;
                        mem_addr  = cnt_q[ADDR_W-1:0];
                        mem_wdata = asm_new;
                        cnt_d     = cnt_q + 1'b1;
                        lane_d    = '0;
                        asm_d     = '0;
                    end else begin
                        asm_d  = asm_new;
                        lane_d = lane_q + 1'b1;
                    end
                    if (ld.ld_last) begin
                        state_d = StReady;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    logic [ADDR_W-1:0] idx;
    logic              in_range;

    assign idx      = A[ADDR_W+1:2];
    assign in_range = (A[31:ADDR_W+2] == '0);
    assign misalign = (A[1:0] != 2'b00);
    assign rd_valid = (state_q == StReady) && in_range && !misalign;
    assign RD       = rd_valid ? mem[idx] : FILL_WORD;
    assign busy     = (state_q != StReady);

    assign ld.ld_ready = (state_q == StLoad);
    assign ld.ld_done  = done_q;
    assign ld.ld_err   = err_q;
    assign ld.ld_count = cnt_q;
endmodule
